// File: rtl/clock_period_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_period_meter_if
// Description : Signal bundle between a measured square-wave source and the
//               clock_period_meter.
//               master : drives sig_in and observes the measurement results.
//               slave  : the meter itself (samples sig_in, drives results).
// Ports       : sig_in        - measured signal (async to clk_in)
//               div_count     - last measured half-period in clk_in cycles
//               measure_valid - one-cycle strobe on each div_count update
//               locked        - repeated identical measurements seen
//               stalled       - no edge within the counter range
//               level         - synchronized level of sig_in
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_period_meter_if #(
  parameter int CLK_DIV_WIDTH = 8
);
  logic                     sig_in;
  logic [CLK_DIV_WIDTH-1:0] div_count;
  logic                     measure_valid;
  logic                     locked;
  logic                     stalled;
  logic                     level;

  modport master (
    output sig_in,
    input  div_count, measure_valid, locked, stalled, level
  );

  modport slave (
    input  sig_in,
    output div_count, measure_valid, locked, stalled, level
  );
endinterface
`default_nettype wire

// File: rtl/clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : clock_period_meter
// Description : Measures the half-period of a slow square wave in clk_in
//               cycles, recovering the divide count that produced it.
//               Reports each measurement with a one-cycle strobe, asserts
//               lock after LOCK_COUNT consecutive matches and flags a stall
//               when the interval counter saturates without an edge.
// Ports       : clk_in - clock, rising edge
//               reset  - synchronous, active-high
//               bus    - clock_period_meter_if.slave (sig_in in, results out)
// Revision    : 1.0 - initial release
// ============================================================================
module clock_period_meter #(
  parameter int CLK_DIV_WIDTH = 8,
  parameter int LOCK_COUNT    = 4
) (
  input  wire logic            clk_in,
  input  wire logic            reset,
  clock_period_meter_if.slave  bus
);

  localparam logic [CLK_DIV_WIDTH-1:0] c_MAX = '1;
  localparam logic [CLK_DIV_WIDTH-1:0] c_ONE = CLK_DIV_WIDTH'(1);
  localparam int                       c_MW  = $clog2(LOCK_COUNT + 1);
  localparam logic [c_MW-1:0]          c_LOCK = c_MW'(LOCK_COUNT);

  logic                     r_s1;
  logic                     r_s2;
  logic                     r_s3;
  logic [CLK_DIV_WIDTH-1:0] r_run_count;
  logic                     r_primed;
  logic                     r_have_meas;  // a measurement exists in this chain
  logic [c_MW-1:0]          r_match_cnt;
  logic [CLK_DIV_WIDTH-1:0] r_div_count;
  logic                     r_valid;
  logic                     r_locked;
  logic                     r_stalled;

  logic                     w_edge;
  logic                     w_at_max;
  logic                     w_meas;
  logic [c_MW-1:0]          w_match_nxt;

  assign w_edge   = r_s2 ^ r_s3;
  assign w_at_max = (r_run_count == c_MAX);

  // Next match count; locked is registered from this same value so that it
  // drops in the very update that breaks the run.
  always_comb begin
    w_meas      = 1'b0;
    w_match_nxt = r_match_cnt;
    if (w_edge) begin
      if (r_primed) begin
        if (!w_at_max) begin
          w_meas = 1'b1;
          if (r_have_meas && (r_run_count == r_div_count)) begin
            w_match_nxt = (r_match_cnt >= c_LOCK) ? c_LOCK : r_match_cnt + 1'b1;
          end else begin
            w_match_nxt = '0;
          end
        end else begin
          // Interval of exactly MAX is indistinguishable from overflow.
          w_match_nxt = '0;
        end
      end
    end else if (w_at_max) begin
      w_match_nxt = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_run_count <= '0;
      r_primed    <= 1'b0;
      r_have_meas <= 1'b0;
      r_match_cnt <= '0;
      r_div_count <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_stalled   <= 1'b0;
    end else begin
      r_s1 <= bus.sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (w_edge) begin
        r_run_count <= c_ONE;
      end else if (!w_at_max) begin
        r_run_count <= r_run_count + 1'b1;
      end

      r_valid     <= w_meas;
      r_match_cnt <= w_match_nxt;
      r_locked    <= (w_match_nxt >= c_LOCK);

      if (w_edge) begin
        if (!r_primed) begin
          r_primed    <= 1'b1;
          r_have_meas <= 1'b0;
          r_stalled   <= 1'b0;
        end else if (!w_at_max) begin
          r_div_count <= r_run_count;
          r_have_meas <= 1'b1;
        end else begin
          // Overflow edge: stays primed because it opens a fresh chain.
          r_have_meas <= 1'b0;
          r_stalled   <= 1'b0;
        end
      end else if (w_at_max) begin
        r_stalled   <= 1'b1;
        r_primed    <= 1'b0;
        r_have_meas <= 1'b0;
      end
    end
  end

  assign bus.div_count     = r_div_count;
  assign bus.measure_valid = r_valid;
  assign bus.locked        = r_locked;
  assign bus.stalled       = r_stalled;
  assign bus.level         = r_s3;

endmodule
`default_nettype wire
